alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_writeback.sv | 98 +++++++++
 tb/tb_alu_writeback.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU writeback types: operation codes, status flags, FSM states, hold register.
// Also holds the wide-op decode used by the writeback stage.
package alu_pkg;

  // The hold register carries dest at this fixed width; RF_ADDR_W must not exceed it.
  localparam int WB_DEST_W = 16;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_MULT = 3'd5,
    ALU_DIV  = 3'd6,
    ALU_NOP  = 3'd7
  } control_e;

  typedef struct packed {
    logic div0;
    logic overflow;
    logic carry;
    logic negative;
    logic zero;
  } status_t;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WR_LO = 2'd1,
    WB_WR_HI = 2'd2
  } wb_state_e;

  typedef struct packed {
    control_e             control;
    logic [31:0]          result;
    status_t              stat;
    logic [WB_DEST_W-1:0] dest;
  } wb_hold_t;

  // MULT and DIV produce a second (high / remainder) word.
  function automatic logic is_wide(input control_e c);
    return (c == ALU_MULT) || (c == ALU_DIV);
  endfunction

  function automatic logic raises_exc(input control_e c, input status_t s);
    return ((c == ALU_DIV) && s.div0) ||
           (((c == ALU_ADD) || (c == ALU_SUB)) && s.overflow);
  endfunction

endpackage

// File: rtl/alu_writeback.sv
// ALU result writeback into the register file; low word 1 cycle after transfer, high word 1 cycle later.
// ready_in drops while stalled or while a MULT/DIV high word is pending; ALU_WB_FORWARD_EN adds fwd_* bypass ports.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int RF_ADDR_W = 4,
  parameter int HI_REG    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  control_e             control,
  input  logic [31:0]          result,
  input  status_t              stat_in,
  input  logic [RF_ADDR_W-1:0] dest,
  input  logic                 stall,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [15:0]          rf_wdata,
  output status_t              flags,
  output logic                 exc
`ifdef ALU_WB_FORWARD_EN
  ,
  output logic                 fwd_valid,
  output logic [RF_ADDR_W-1:0] fwd_addr,
  output logic [15:0]          fwd_data
`endif
);

  wb_state_e state;
  wb_state_e state_nxt;
  wb_hold_t  hold;

  logic active;
  logic wide;
  logic skip_lo;
  logic transfer;

  // Outputs are gated by rst_n so an edge that resets the FSM never commits a write.
  assign active   = rst_n && !stall;
  assign wide     = is_wide(hold.control);
  assign skip_lo  = (hold.control == ALU_DIV) && hold.stat.div0;
  assign transfer = valid_in && ready_in;

  always_comb begin
    ready_in = active && ((state == WB_IDLE) || (state == WB_WR_HI) ||
                          ((state == WB_WR_LO) && !wide));
  end

  always_comb begin
    rf_we    = active && (((state == WB_WR_LO) && !skip_lo) || (state == WB_WR_HI));
    rf_waddr = (state == WB_WR_HI) ? RF_ADDR_W'(HI_REG) : hold.dest[RF_ADDR_W-1:0];
    rf_wdata = (state == WB_WR_HI) ? hold.result[31:16] : hold.result[15:0];
    exc      = active && (state == WB_WR_LO) && raises_exc(hold.control, hold.stat);
  end

  always_comb begin
    state_nxt = state;
    if (!stall) begin
      case (state)
        WB_IDLE:  if (transfer) state_nxt = WB_WR_LO;
        WB_WR_LO: begin
          if (wide && !skip_lo) state_nxt = WB_WR_HI;
          else if (transfer)    state_nxt = WB_WR_LO;
          else                  state_nxt = WB_IDLE;
        end
        WB_WR_HI: state_nxt = transfer ? WB_WR_LO : WB_IDLE;
        default:  state_nxt = WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WB_IDLE;
      hold  <= '0;
      flags <= '0;
    end else begin
      state <= state_nxt;
      if (transfer) begin
        hold.control <= control;
        hold.result  <= result;
        hold.stat    <= stat_in;
        hold.dest    <= WB_DEST_W'(dest);
      end
      // Flags commit with the low-word cycle, including the suppressed div0 write.
      if (!stall && (state == WB_WR_LO)) flags <= hold.stat;
    end
  end

`ifdef ALU_WB_FORWARD_EN
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed and randomized checks of alu_writeback against an in-bench write-sequence model.
module tb_alu_writeback;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic       stall = 1'b0;
  control_e   control = ALU_NOP;
  logic [31:0] result = '0;
  status_t    stat_in = '0;
  logic [3:0] dest = '0;

  logic       ready_in;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [15:0] rf_wdata;
  status_t    flags;
  logic       exc;

  int npass = 0;
  int ntot  = 0;

  logic [19:0] expq[$];
  int          exp_exc = 0;
  int          got_exc = 0;
  status_t     exp_flags = '0;

  alu_writeback #(.RF_ADDR_W(4), .HI_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .control(control), .result(result), .stat_in(stat_in), .dest(dest),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags(flags), .exc(exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic chk_wr(input string tag, input logic [3:0] a, input logic [15:0] d);
    chk({tag, "_we"}, 32'(rf_we), 32'd1);
    chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, "_data"}, 32'(rf_wdata), 32'(d));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input control_e c, input logic [31:0] r,
                       input status_t s, input logic [3:0] d);
    valid_in = v;
    control  = c;
    result   = r;
    stat_in  = s;
    dest     = d;
  endtask

  task automatic monitor();
    logic [19:0] e;
    if (stall) chk("rnd_stall_no_write", 32'(rf_we), 32'd0);
    if (rf_we) begin
      if (expq.size() == 0) chk("rnd_spurious_write", 32'd1, 32'd0);
      else begin
        e = expq.pop_front();
        chk("rnd_waddr", 32'(rf_waddr), 32'(e[19:16]));
        chk("rnd_wdata", 32'(rf_wdata), 32'(e[15:0]));
      end
    end
    if (exc) got_exc++;
  endtask

  // Expected register-file writes per accepted result, straight from the operation rules.
  task automatic model_push();
    if (control == ALU_DIV && stat_in.div0) begin
      exp_exc++;
    end else begin
      expq.push_back({dest, result[15:0]});
      if (control == ALU_MULT || control == ALU_DIV)
        expq.push_back({4'd0, result[31:16]});
      if ((control == ALU_ADD || control == ALU_SUB) && stat_in.overflow)
        exp_exc++;
    end
    exp_flags = stat_in;
  endtask

  initial begin
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(ready_in), 32'd1);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);

    // ADD single-word write
    drive(1'b1, ALU_ADD, 32'h0000_1234, 5'b00100, 4'd3);
    #1;
    chk("add_ready", 32'(ready_in), 32'd1);
    cyc();
    drive(1'b0, ALU_NOP, '0, '0, '0);
    #1;
    chk_wr("add_wr", 4'd3, 16'h1234);
    chk("add_exc", 32'(exc), 32'd0);
    cyc();
    #1;
    chk("add_flags", 32'(flags), 32'h04);
    chk("add_idle_we", 32'(rf_we), 32'd0);

    // MULT two-word write
    drive(1'b1, ALU_MULT, 32'h0001_E240, 5'b00000, 4'd5);
    cyc();
    drive(1'b0, ALU_NOP, '0, '0, '0);
    #1;
    chk_wr("mult_lo", 4'd5, 16'hE240);
    chk("mult_lo_ready", 32'(ready_in), 32'd0);
    cyc();
    #1;
    chk_wr("mult_hi", 4'd0, 16'h0001);
    chk("mult_hi_ready", 32'(ready_in), 32'd1);
    cyc();
    #1;
    chk("mult_done_we", 32'(rf_we), 32'd0);

    // DIV by zero: no writes, one exc pulse
    drive(1'b1, ALU_DIV, 32'h0000_0000, 5'b10000, 4'd2);
    cyc();
    drive(1'b0, ALU_NOP, '0, '0, '0);
    #1;
    chk("div0_lo_we", 32'(rf_we), 32'd0);
    chk("div0_exc", 32'(exc), 32'd1);
    cyc();
    #1;
    chk("div0_next_we", 32'(rf_we), 32'd0);
    chk("div0_exc_end", 32'(exc), 32'd0);
    chk("div0_ready", 32'(ready_in), 32'd1);
    chk("div0_flags", 32'(flags.div0), 32'd1);

    // Back-to-back ORs
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, ALU_OR, 32'(i * 16'h0111), 5'b00000, 4'(i));
      #1;
      chk("or_ready", 32'(ready_in), 32'd1);
      if (i > 1) chk_wr("or_wr", 4'(i - 1), 16'((i - 1) * 16'h0111));
      cyc();
    end
    drive(1'b0, ALU_NOP, '0, '0, '0);
    #1;
    chk_wr("or_wr_last", 4'd4, 16'h0444);
    cyc();

    // MULT held by stall in WR_LO
    drive(1'b1, ALU_MULT, 32'hABCD_5678, 5'b00000, 4'd7);
    cyc();
    drive(1'b0, ALU_NOP, '0, '0, '0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_we", 32'(rf_we), 32'd0);
      chk("stall_ready", 32'(ready_in), 32'd0);
      cyc();
    end
    stall = 1'b0;
    #1;
    chk_wr("stall_lo", 4'd7, 16'h5678);
    cyc();
    #1;
    chk_wr("stall_hi", 4'd0, 16'hABCD);
    cyc();

    // ADD overflow still writes and raises exc
    drive(1'b1, ALU_ADD, 32'h0000_8000, 5'b01000, 4'd9);
    cyc();
    drive(1'b0, ALU_NOP, '0, '0, '0);
    #1;
    chk_wr("ovf_wr", 4'd9, 16'h8000);
    chk("ovf_exc", 32'(exc), 32'd1);
    cyc();
    #1;
    chk("ovf_exc_end", 32'(exc), 32'd0);

    // MULT targeting the high register: low then high, in order
    drive(1'b1, ALU_MULT, 32'hBEEF_0011, 5'b00000, 4'd0);
    cyc();
    drive(1'b0, ALU_NOP, '0, '0, '0);
    #1;
    chk_wr("hireg_lo", 4'd0, 16'h0011);
    cyc();
    #1;
    chk_wr("hireg_hi", 4'd0, 16'hBEEF);
    cyc();

    // Reset during WR_HI of a DIV
    drive(1'b1, ALU_DIV, 32'h0003_0004, 5'b00001, 4'd6);
    cyc();
    drive(1'b0, ALU_NOP, '0, '0, '0);
    #1;
    chk_wr("rdiv_lo", 4'd6, 16'h0004);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rdiv_hi_we", 32'(rf_we), 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rdiv_after_we", 32'(rf_we), 32'd0);
    chk("rdiv_flags", 32'(flags), 32'd0);
    chk("rdiv_ready", 32'(ready_in), 32'd1);
    cyc();
    #1;
    chk("rdiv_idle_we", 32'(rf_we), 32'd0);

    // Randomized traffic with random stalls
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, control_e'($urandom_range(0, 7)), $urandom,
            status_t'(5'($urandom_range(0, 31))), 4'($urandom_range(0, 15)));
      stall = ($urandom_range(0, 4) == 0);
      #1;
      monitor();
      if (valid_in && ready_in) model_push();
      cyc();
    end
    drive(1'b0, ALU_NOP, '0, '0, '0);
    stall = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1;
      monitor();
      cyc();
    end
    chk("rnd_pending_writes", 32'(expq.size()), 32'd0);
    chk("rnd_exc_count", 32'(got_exc), 32'(exp_exc));
    chk("rnd_flags", 32'(flags), 32'(exp_flags));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
